// File: rtl/gb_capture.sv
// gb_capture: samples the raw Game Boy LCD tap in the PLL clock domain,
// deglitches hsync/vsync/pixel-clock with a 4-sample agreement filter and
// emits one framebuffer write per GB pixel (linear address, inverted shade).
// Also reports frame starts, address overflow and GB signal presence.
module gb_capture #(
  parameter int unsigned H_PIXELS       = 160,
  parameter int unsigned V_LINES        = 144,
  parameter int unsigned DATA_DELAY     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  idata,
  input  logic        ihsync,
  input  logic        ivsync,
  input  logic        iclk,
  output logic        pix_valid,
  output logic [14:0] pix_addr,
  output logic [1:0]  pix_data,
  output logic        frame_start,
  output logic        ovf_err,
  output logic        signal_present
);

  localparam int unsigned FB_SIZE = H_PIXELS * V_LINES;
  localparam logic [14:0] FB_END  = 15'(FB_SIZE);
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  // strobe bit positions inside the packed filter vectors
  localparam int unsigned HS = 0;
  localparam int unsigned VS = 1;
  localparam int unsigned CK = 2;

  logic [2:0] raw;
  logic [2:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, s_q, s_d;
  logic [2:0] rise, fall;

  logic [DATA_DELAY-1:0][1:0] dly_q, dly_d;

  logic          pix_event;
  logic [14:0]   ipixel_q, ipixel_d;
  logic          pix_valid_q, pix_valid_d;
  logic [14:0]   pix_addr_q, pix_addr_d;
  logic [1:0]    pix_data_q, pix_data_d;
  logic          frame_start_q, frame_start_d;
  logic          ovf_err_q, ovf_err_d;
  logic          present_q, present_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  assign raw = {iclk, ivsync, ihsync};

  // Agreement filter: state flips only when raw input and three history samples agree.
  always_comb begin
    p1_d = raw;
    p2_d = p1_q;
    p3_d = p2_q;
    rise = raw & p1_q & p2_q & p3_q & ~s_q;
    fall = ~raw & ~p1_q & ~p2_q & ~p3_q & s_q;
    s_d  = (s_q | rise) & ~fall;
  end

  // Pixel write generation, overflow tracking, frame start and presence watchdog.
  always_comb begin
    dly_d         = {dly_q[DATA_DELAY-2:0], idata};
    // a coincident hsync fall and iclk fall is a single event
    pix_event     = (fall[CK] & ~s_q[HS]) | fall[HS];
    pix_valid_d   = 1'b0;
    pix_addr_d    = pix_addr_q;
    pix_data_d    = pix_data_q;
    ipixel_d      = ipixel_q;
    ovf_err_d     = ovf_err_q;
    frame_start_d = 1'b0;
    to_cnt_d      = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    present_d     = (to_cnt_q == TO_MAX) ? 1'b0 : present_q;

    if (pix_event) begin
      if (ipixel_q == FB_END) begin
        ovf_err_d = 1'b1;
      end else begin
        pix_valid_d = 1'b1;
        pix_addr_d  = ipixel_q;
        pix_data_d  = ~dly_q[DATA_DELAY-1];
        ipixel_d    = ipixel_q + 15'd1;
      end
    end

    // vsync overrides the increment; a coincident write still used the old address
    if (rise[VS]) begin
      ipixel_d      = '0;
      frame_start_d = 1'b1;
      to_cnt_d      = '0;
      present_d     = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_q          <= '0;
      p2_q          <= '0;
      p3_q          <= '0;
      s_q           <= '0;
      dly_q         <= '0;
      ipixel_q      <= '0;
      pix_valid_q   <= 1'b0;
      pix_addr_q    <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      ovf_err_q     <= 1'b0;
      present_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      p3_q          <= p3_d;
      s_q           <= s_d;
      dly_q         <= dly_d;
      ipixel_q      <= ipixel_d;
      pix_valid_q   <= pix_valid_d;
      pix_addr_q    <= pix_addr_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      ovf_err_q     <= ovf_err_d;
      present_q     <= present_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign pix_valid      = pix_valid_q;
  assign pix_addr       = pix_addr_q;
  assign pix_data       = pix_data_q;
  assign frame_start    = frame_start_q;
  assign ovf_err        = ovf_err_q;
  assign signal_present = present_q;

endmodule

// File: tb/tb_gb_capture.sv
// Testbench for gb_capture: scoreboard of expected writes plus a table of
// data-alignment vectors and hand sequences for the multi-cycle corner cases.
module tb_gb_capture;

  localparam int unsigned H  = 160;
  localparam int unsigned V  = 8;
  localparam int unsigned FB = H * V;
  localparam int unsigned PH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  idata;
  logic        ihsync, ivsync, iclk;
  logic        pix_valid;
  logic [14:0] pix_addr;
  logic [1:0]  pix_data;
  logic        frame_start, ovf_err, signal_present;

  gb_capture #(
    .H_PIXELS(H),
    .V_LINES(V),
    .DATA_DELAY(5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .idata(idata),
    .ihsync(ihsync),
    .ivsync(ivsync),
    .iclk(iclk),
    .pix_valid(pix_valid),
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .frame_start(frame_start),
    .ovf_err(ovf_err),
    .signal_present(signal_present)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    int         j;
    logic [1:0] exp_data;
  } vec_t;

  wr_t  sb[$];
  wr_t  mon_e;
  vec_t tbl[5];

  int total    = 0;
  int bad      = 0;
  int exp_ipix = 0;
  int fs_exp   = 0;
  int fs_seen  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected write for an event whose falling strobe is driven now
  task automatic push(input logic [1:0] pd);
    if (exp_ipix < int'(FB)) begin
      sb.push_back('{addr: 15'(exp_ipix), data: pd, cyc: cyc + 4});
      exp_ipix++;
    end
  endtask

  task automatic pixel(input logic [1:0] d);
    idata = d;
    iclk  = 1'b1;
    tick(PH);
    iclk = 1'b0;
    push(~d);
    tick(PH);
  endtask

  task automatic pixel_late(input logic [1:0] a, input logic [1:0] b,
                            input int j, input logic [1:0] ed);
    idata = a;
    iclk  = 1'b1;
    tick(PH - j);
    idata = b;
    tick(j);
    iclk = 1'b0;
    push(ed);
    tick(PH);
  endtask

  task automatic hline(input logic [1:0] d);
    idata  = d;
    ihsync = 1'b1;
    iclk   = 1'b1;
    tick(PH);
    ihsync = 1'b0;
    push(~d);
    tick(PH);
  endtask

  task automatic vsync();
    ivsync   = 1'b1;
    exp_ipix = 0;
    fs_exp++;
    tick(PH);
    ivsync = 1'b0;
    tick(PH);
  endtask

  // scoreboard / frame-start monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                 pix_addr, pix_data);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", int'(pix_addr), int'(mon_e.addr));
        check("wr_data", int'(pix_data), int'(mon_e.data));
        check("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 2'd0, b: 2'd3, j: 0, exp_data: 2'b11};
    tbl[1] = '{a: 2'd1, b: 2'd2, j: 1, exp_data: 2'b10};
    tbl[2] = '{a: 2'd2, b: 2'd1, j: 2, exp_data: 2'b10};
    tbl[3] = '{a: 2'd3, b: 2'd0, j: 3, exp_data: 2'b11};
    tbl[4] = '{a: 2'd0, b: 2'd2, j: 4, exp_data: 2'b01};

    // reset with vsync already high: outputs zero, then a frame start 4 edges later
    rst_n  = 1'b0;
    idata  = 2'd0;
    ihsync = 1'b1;
    ivsync = 1'b1;
    iclk   = 1'b1;
    tick(3);
    check("reset_outs", int'({pix_valid, pix_addr, pix_data, frame_start, ovf_err, signal_present}), 0);
    rst_n = 1'b1;
    tick(3);
    check("por_fs_early", int'(frame_start), 0);
    tick(1);
    check("por_fs", int'(frame_start), 1);
    check("por_present", int'(signal_present), 1);
    fs_exp++;
    ivsync = 1'b0;
    tick(PH);

    // clean line: hsync fall then 159 pixel clocks
    vsync();
    hline(2'b01);
    for (int i = 1; i < int'(H); i++) pixel(2'(i % 4));
    check("clean_fs", fs_seen, fs_exp);
    check("clean_drained", sb.size(), 0);

    // glitches: 3-cycle iclk low, 2-cycle vsync high
    iclk = 1'b1;
    tick(PH);
    iclk = 1'b0;
    tick(3);
    iclk = 1'b1;
    tick(PH);
    ivsync = 1'b1;
    tick(2);
    ivsync = 1'b0;
    tick(PH);
    check("glitch_fs", fs_seen, fs_exp);
    check("glitch_drained", sb.size(), 0);
    pixel(2'd2);

    // data alignment vectors
    for (int k = 0; k < 5; k++) pixel_late(tbl[k].a, tbl[k].b, tbl[k].j, tbl[k].exp_data);

    // coincident hsync fall and iclk fall at 320
    while (exp_ipix < 320) pixel(2'(exp_ipix % 4));
    idata  = 2'd3;
    ihsync = 1'b1;
    iclk   = 1'b1;
    tick(PH);
    ihsync = 1'b0;
    iclk   = 1'b0;
    push(2'b00);
    tick(PH);
    pixel(2'd1);
    check("coinc_hs_drained", sb.size(), 0);

    // vsync rise coinciding with an event at 500
    while (exp_ipix < 500) pixel(2'(exp_ipix % 4));
    idata = 2'd2;
    iclk  = 1'b1;
    tick(PH);
    ivsync = 1'b1;
    iclk   = 1'b0;
    push(2'b01);
    exp_ipix = 0;
    fs_exp++;
    tick(PH);
    ivsync = 1'b0;
    tick(PH);
    pixel(2'd0);
    check("coinc_vs_fs", fs_seen, fs_exp);
    check("coinc_vs_drained", sb.size(), 0);

    // watchdog: 100 cycles of presence after a vsync commit
    tick(120);
    check("wd_low_before", int'(signal_present), 0);
    ivsync = 1'b1;
    tick(3);
    check("wd_fs_n3", int'(frame_start), 0);
    check("wd_present_n3", int'(signal_present), 0);
    tick(1);
    check("wd_fs_n4", int'(frame_start), 1);
    check("wd_present_n4", int'(signal_present), 1);
    fs_exp++;
    exp_ipix = 0;
    tick(1);
    check("wd_fs_n5", int'(frame_start), 0);
    ivsync = 1'b0;
    tick(98);
    check("wd_present_last", int'(signal_present), 1);
    tick(1);
    check("wd_present_drop", int'(signal_present), 0);
    tick(PH);
    ivsync = 1'b1;
    tick(4);
    check("wd_present_back", int'(signal_present), 1);
    fs_exp++;
    ivsync = 1'b0;
    tick(PH);

    // overflow: FB+1 events in one frame
    vsync();
    for (int i = 0; i < int'(FB); i++) pixel(2'(i % 4));
    check("ovf_before", int'(ovf_err), 0);
    pixel(2'd1);
    check("ovf_set", int'(ovf_err), 1);
    check("ovf_drained", sb.size(), 0);
    vsync();
    pixel(2'd2);
    check("ovf_sticky", int'(ovf_err), 1);

    // reset mid-frame at 1000 with an iclk fall pending
    while (exp_ipix < 1000) pixel(2'(exp_ipix % 4));
    idata = 2'd1;
    iclk  = 1'b1;
    tick(PH);
    iclk = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_outs", int'({pix_valid, pix_addr, pix_data, frame_start, ovf_err, signal_present}), 0);
    rst_n    = 1'b1;
    exp_ipix = 0;
    check("rst_mid_drained", sb.size(), 0);
    tick(PH);
    hline(2'd3);
    tick(PH);

    check("final_fs", fs_seen, fs_exp);
    check("final_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
